// File: rtl/seq_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_cmd_arbiter
// Description : Shares one device command bus between four sequencers. Each
//               sequencer feeds a private 2-entry FIFO. A round-robin arbiter
//               forwards one queued command per cycle onto the registered
//               shared bus. A per-port hold tells the system to stall that
//               sequencer while it has anything queued.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_cmd_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] oreg_0,
  input  logic [11:0] oreg_1,
  input  logic [11:0] oreg_2,
  input  logic [11:0] oreg_3,
  input  logic [7:0]  oreg_wen_0,
  input  logic [7:0]  oreg_wen_1,
  input  logic [7:0]  oreg_wen_2,
  input  logic [7:0]  oreg_wen_3,
  output logic        hold_0,
  output logic        hold_1,
  output logic        hold_2,
  output logic        hold_3,
  output logic [11:0] oreg,
  output logic [7:0]  oreg_wen,
  output logic [3:0]  grant,
  output logic        error
);

  localparam int NPORT = 4;

  // Each FIFO entry is {cmd/arg word, device enable}.
  logic [11:0] in_cmd [NPORT];
  logic [7:0]  in_wen [NPORT];

  logic [19:0] mem_q   [NPORT][2];
  logic [1:0]  count_q [NPORT];
  logic [1:0]  count_d [NPORT];
  logic [3:0]  head_q;
  logic [3:0]  tail_q;
  logic [3:0]  hold_q;

  logic [1:0]  ptr_q;
  logic [11:0] oreg_q;
  logic [7:0]  oreg_wen_q;
  logic [3:0]  grant_q;
  logic        error_q;

  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic [19:0] head_ent;

  logic [3:0]  enq;
  logic [3:0]  deq;
  logic [3:0]  accept;
  logic [3:0]  ovf;

  assign in_cmd[0] = oreg_0;
  assign in_cmd[1] = oreg_1;
  assign in_cmd[2] = oreg_2;
  assign in_cmd[3] = oreg_3;
  assign in_wen[0] = oreg_wen_0;
  assign in_wen[1] = oreg_wen_1;
  assign in_wen[2] = oreg_wen_2;
  assign in_wen[3] = oreg_wen_3;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = ptr_q;
    cand      = 2'd0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_valid && (count_q[cand] != 2'd0)) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign head_ent = mem_q[win_idx][head_q[win_idx]];

  // Per-port FIFO control: a dequeue in the same cycle frees the slot an
  // enqueue at full would otherwise overflow.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      enq[i]     = (in_wen[i] != 8'd0);
      deq[i]     = win_valid && (win_idx == 2'(i));
      accept[i]  = enq[i] && ((count_q[i] != 2'd2) || deq[i]);
      ovf[i]     = enq[i] && (count_q[i] == 2'd2) && !deq[i];
      count_d[i] = count_q[i] + {1'b0, accept[i]} - {1'b0, deq[i]};
    end
  end

  // FIFO storage; contents need no reset since counts gate every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NPORT; i++) begin
      if (accept[i]) begin
        mem_q[i][tail_q[i]] <= {in_cmd[i], in_wen[i]};
      end
    end
  end

  // FIFO pointers, counts, holds, arbiter pointer, output bus and error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NPORT; i++) begin
        count_q[i] <= 2'd0;
      end
      head_q     <= 4'd0;
      tail_q     <= 4'd0;
      hold_q     <= 4'd0;
      ptr_q      <= 2'd3;
      oreg_q     <= 12'd0;
      oreg_wen_q <= 8'd0;
      grant_q    <= 4'd0;
      error_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        count_q[i] <= count_d[i];
        hold_q[i]  <= (count_d[i] != 2'd0);
      end
      head_q <= head_q ^ deq;
      tail_q <= tail_q ^ accept;
      if (win_valid) begin
        oreg_q     <= head_ent[19:8];
        oreg_wen_q <= head_ent[7:0];
        grant_q    <= 4'b0001 << win_idx;
        ptr_q      <= win_idx;
      end else begin
        oreg_q     <= 12'd0;
        oreg_wen_q <= 8'd0;
        grant_q    <= 4'd0;
      end
      if (ovf != 4'd0) begin
        error_q <= 1'b1;
      end
    end
  end

  assign hold_0   = hold_q[0];
  assign hold_1   = hold_q[1];
  assign hold_2   = hold_q[2];
  assign hold_3   = hold_q[3];
  assign oreg     = oreg_q;
  assign oreg_wen = oreg_wen_q;
  assign grant    = grant_q;
  assign error    = error_q;

endmodule
`default_nettype wire
